apb_multi_slave_master: RTL and testbench



---
 rtl/apb_multi_slave_master.sv | 180 ++++++++++++++++++
 tb/tb_apb_multi_slave_master.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_multi_slave_master.sv
// apb_multi_slave_master: single-command bridge to an APB3 bus with NUM_SLAVES
// slaves. The upper address bits select the slave. The block adds a decode-error
// response, a wait-state timeout and a one-cycle done pulse back to the bridge.
// Optional macro APB4_PSTRB_EN adds the APB4 strobe (pstrb) and protection
// (pprot) sideband signals, which are captured together with the address.
module apb_multi_slave_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                           pclk,
  input  logic                           preset_n,
  input  logic                           trans_i,
  input  logic [ADDR_WIDTH-1:0]          addr_i,
  input  logic [DATA_WIDTH-1:0]          wdata_i,
  input  logic                           wr_rd_i,
`ifdef APB4_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0]        strb_i,
  input  logic [2:0]                     prot_i,
  output logic [DATA_WIDTH/8-1:0]        pstrb,
  output logic [2:0]                     pprot,
`endif
  output logic                           ready_o,
  output logic                           done_o,
  output logic [DATA_WIDTH-1:0]          rdata_o,
  output logic                           trans_err_o,
  output logic [NUM_SLAVES-1:0]          pselx,
  output logic                           penable,
  output logic                           pwrite,
  output logic [ADDR_WIDTH-1:0]          paddr,
  output logic [DATA_WIDTH-1:0]          pwdata,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]          pready,
  input  logic [NUM_SLAVES-1:0]          pslverr
);

  localparam int SEL_BITS = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [SEL_BITS:0] NUM_SEL  = (SEL_BITS + 1)'(NUM_SLAVES);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        wait_cnt_q, wait_cnt_d;
  logic [NUM_SLAVES-1:0]   pselx_d;
  logic                    penable_d, pwrite_d, done_d, err_d, ready_d;
  logic [ADDR_WIDTH-1:0]   paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_d, rdata_d;
  logic [SEL_BITS-1:0]     sel_k;
  logic                    dec_ok;
  logic [NUM_SLAVES-1:0]   sel_onehot;
  logic                    sel_ready, sel_err;
  logic [DATA_WIDTH-1:0]   sel_rdata;
`ifdef APB4_PSTRB_EN
  logic [DATA_WIDTH/8-1:0] pstrb_d;
  logic [2:0]              pprot_d;
`endif

  assign sel_k     = addr_i[ADDR_WIDTH-1 -: SEL_BITS];
  assign dec_ok    = ({1'b0, sel_k} < NUM_SEL);
  // Only the currently selected slave may answer; pselx is one-hot or zero.
  assign sel_ready = |(pready & pselx);
  assign sel_err   = |(pslverr & pselx);

  // Decode the slave index into a one-hot select and mux the selected read data.
  always_comb begin
    sel_onehot = '0;
    sel_rdata  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel_onehot[i] = ({1'b0, sel_k} == (SEL_BITS + 1)'(i));
      if (pselx[i]) sel_rdata = sel_rdata | prdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    pselx_d    = pselx;
    penable_d  = penable;
    pwrite_d   = pwrite;
    paddr_d    = paddr;
    pwdata_d   = pwdata;
    done_d     = 1'b0;
    err_d      = 1'b0;
    rdata_d    = '0;
`ifdef APB4_PSTRB_EN
    pstrb_d    = pstrb;
    pprot_d    = pprot;
`endif
    case (state_q)
      IDLE: begin
        if (trans_i) begin
          if (dec_ok) begin
            state_d    = SETUP;
            wait_cnt_d = '0;
            pselx_d    = sel_onehot;
            penable_d  = 1'b0;
            paddr_d    = addr_i;
            pwrite_d   = wr_rd_i;
            pwdata_d   = wr_rd_i ? wdata_i : '0;
`ifdef APB4_PSTRB_EN
            pstrb_d    = wr_rd_i ? strb_i : '0;
            pprot_d    = prot_i;
`endif
          end else begin
            // Address outside the slave range: answer with an error, no bus cycle.
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (sel_ready) begin
          state_d   = IDLE;
          pselx_d   = '0;
          penable_d = 1'b0;
          done_d    = 1'b1;
          err_d     = sel_err;
          rdata_d   = pwrite ? '0 : sel_rdata;
        end else if (TIMEOUT_CYCLES > 0 && wait_cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          pselx_d   = '0;
          penable_d = 1'b0;
          done_d    = 1'b1;
          err_d     = 1'b1;
        end else if (wait_cnt_q != CNT_MAX) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  // State, wait counter and all bus/bridge outputs, cleared asynchronously.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      pselx       <= '0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      done_o      <= 1'b0;
      trans_err_o <= 1'b0;
      rdata_o     <= '0;
      ready_o     <= 1'b0;
`ifdef APB4_PSTRB_EN
      pstrb       <= '0;
      pprot       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      pselx       <= pselx_d;
      penable     <= penable_d;
      pwrite      <= pwrite_d;
      paddr       <= paddr_d;
      pwdata      <= pwdata_d;
      done_o      <= done_d;
      trans_err_o <= err_d;
      rdata_o     <= rdata_d;
      ready_o     <= ready_d;
`ifdef APB4_PSTRB_EN
      pstrb       <= pstrb_d;
      pprot       <= pprot_d;
`endif
    end
  end

endmodule

// File: tb/tb_apb_multi_slave_master.sv
// Testbench for apb_multi_slave_master: table of directed transfers on a
// 4-slave instance plus hand-written reset, timeout, back-to-back and
// decode-error sequences (the latter on a 3-slave instance).
module tb_apb_multi_slave_master;

  logic         pclk, preset_n;
  // 4-slave instance
  logic         trans, wr;
  logic [31:0]  addr, wdata;
  logic         ready, done, err, penable, pwrite;
  logic [31:0]  rdata, paddr, pwdata;
  logic [3:0]   pselx, pready, pslverr;
  logic [127:0] prdata;
  // 3-slave instance
  logic         trans3, wr3;
  logic [31:0]  addr3, wdata3;
  logic         ready3, done3, err3, penable3, pwrite3;
  logic [31:0]  rdata3, paddr3, pwdata3;
  logic [2:0]   pselx3, pready3, pslverr3;
  logic [95:0]  prdata3;

  int n_vec  = 0;
  int n_miss = 0;

  apb_multi_slave_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(4), .TIMEOUT_CYCLES(16)) dut (
    .pclk(pclk), .preset_n(preset_n), .trans_i(trans), .addr_i(addr), .wdata_i(wdata),
    .wr_rd_i(wr), .ready_o(ready), .done_o(done), .rdata_o(rdata), .trans_err_o(err),
    .pselx(pselx), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr));

  apb_multi_slave_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(3), .TIMEOUT_CYCLES(16)) dut3 (
    .pclk(pclk), .preset_n(preset_n), .trans_i(trans3), .addr_i(addr3), .wdata_i(wdata3),
    .wr_rd_i(wr3), .ready_o(ready3), .done_o(done3), .rdata_o(rdata3), .trans_err_o(err3),
    .pselx(pselx3), .penable(penable3), .pwrite(pwrite3), .paddr(paddr3), .pwdata(pwdata3),
    .prdata(prdata3), .pready(pready3), .pslverr(pslverr3));

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic        slv_err;
    logic [31:0] slv_rdata;
    logic [3:0]  exp_sel;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One table transfer; unselected slaves keep pready/pslverr high to show they are ignored.
  task automatic apply(input int idx, input vec_t v);
    string p;
    p = $sformatf("v%0d", idx);
    for (int k = 0; k < 4; k++)
      prdata[k*32 +: 32] = v.exp_sel[k] ? v.slv_rdata : (32'hBAD0_0000 | 32'(k));
    pready  = ~v.exp_sel;
    pslverr = ~v.exp_sel | (v.slv_err ? v.exp_sel : 4'b0000);
    @(negedge pclk);
    trans = 1'b1; wr = v.wr; addr = v.addr; wdata = v.wdata;
    @(negedge pclk);
    trans = 1'b0;
    check({p, " setup pselx"},   32'(pselx), 32'(v.exp_sel));
    check({p, " setup penable"}, 32'(penable), 32'd0);
    check({p, " setup ready"},   32'(ready), 32'd0);
    check({p, " paddr"},         paddr, v.addr);
    check({p, " pwrite"},        32'(pwrite), 32'(v.wr));
    check({p, " pwdata"},        pwdata, v.wr ? v.wdata : 32'd0);
    for (int j = 0; j <= v.waits; j++) begin
      @(negedge pclk);
      check($sformatf("%s access%0d penable", p, j), 32'(penable), 32'd1);
      check($sformatf("%s access%0d done", p, j), 32'(done), 32'd0);
      pready = ~v.exp_sel | ((j == v.waits) ? v.exp_sel : 4'b0000);
    end
    @(negedge pclk);
    pready = ~v.exp_sel;
    check({p, " done"},      32'(done), 32'd1);
    check({p, " err"},       32'(err), 32'(v.exp_err));
    check({p, " rdata"},     rdata, v.exp_rdata);
    check({p, " end pselx"}, 32'(pselx), 32'd0);
    check({p, " end penable"}, 32'(penable), 32'd0);
    check({p, " end ready"}, 32'(ready), 32'd1);
    @(negedge pclk);
    check({p, " done cleared"},  32'(done), 32'd0);
    check({p, " rdata cleared"}, rdata, 32'd0);
    check({p, " err cleared"},   32'(err), 32'd0);
  endtask

  initial begin
    int cnt;
    //          wr    addr           wdata          waits err   slv_rdata      sel      exp_rdata      exp_err
    tbl[0] = '{1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 0, 1'b0, 32'h0000_0000, 4'b0010, 32'h0000_0000, 1'b0};
    tbl[1] = '{1'b0, 32'hC000_0004, 32'hFFFF_FFFF, 2, 1'b0, 32'h1234_5678, 4'b1000, 32'h1234_5678, 1'b0};
    tbl[2] = '{1'b1, 32'h8000_0020, 32'h0000_00FF, 0, 1'b1, 32'h0000_0000, 4'b0100, 32'h0000_0000, 1'b1};
    tbl[3] = '{1'b0, 32'h0000_0008, 32'h0000_0000, 1, 1'b0, 32'hCAFE_F00D, 4'b0001, 32'hCAFE_F00D, 1'b0};
    tbl[4] = '{1'b0, 32'h8000_0000, 32'h1111_1111, 0, 1'b1, 32'h5555_AAAA, 4'b0100, 32'h5555_AAAA, 1'b1};

    preset_n = 1'b0;
    trans = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    prdata = '0; pready = '0; pslverr = '0;
    trans3 = 1'b0; wr3 = 1'b0; addr3 = '0; wdata3 = '0;
    prdata3 = '1; pready3 = 3'b111; pslverr3 = 3'b000;

    // Reset state
    repeat (2) @(negedge pclk);
    check("reset pselx",   32'(pselx), 32'd0);
    check("reset penable", 32'(penable), 32'd0);
    check("reset done",    32'(done), 32'd0);
    check("reset ready",   32'(ready), 32'd0);
    check("reset rdata",   rdata, 32'd0);
    check("reset paddr",   paddr, 32'd0);
    preset_n = 1'b1;
    @(negedge pclk);
    check("post-reset ready", 32'(ready), 32'd1);

    // Table-driven transfers
    for (int i = 0; i < 5; i++) apply(i, tbl[i]);

    // Timeout: slave 0 never ready, others ready but ignored
    prdata  = {32'hBAD0_0003, 32'hBAD0_0002, 32'hBAD0_0001, 32'h7777_7777};
    pready  = 4'b1110;
    pslverr = 4'b1110;
    @(negedge pclk);
    trans = 1'b1; wr = 1'b0; addr = 32'h0000_0004;
    @(negedge pclk);
    trans = 1'b0;
    check("timeout setup pselx", 32'(pselx), 32'b0001);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge pclk);
      if (!penable) break;
      cnt++;
    end
    check("timeout access cycles", 32'(cnt), 32'd16);
    check("timeout done",  32'(done), 32'd1);
    check("timeout err",   32'(err), 32'd1);
    check("timeout rdata", rdata, 32'd0);
    check("timeout pselx", 32'(pselx), 32'd0);
    @(negedge pclk);
    check("timeout done cleared", 32'(done), 32'd0);

    // Back-to-back writes with trans_i held high
    pready = 4'b1111; pslverr = 4'b0000;
    @(negedge pclk);
    trans = 1'b1; wr = 1'b1; addr = 32'h0000_0000; wdata = 32'h1111_1111;
    @(negedge pclk);
    check("b2b first pselx", 32'(pselx), 32'b0001);
    addr = 32'h4000_0000; wdata = 32'h2222_2222;
    @(negedge pclk);
    check("b2b first penable", 32'(penable), 32'd1);
    check("b2b first paddr held", paddr, 32'h0000_0000);
    @(negedge pclk);
    check("b2b first done",  32'(done), 32'd1);
    check("b2b first ready", 32'(ready), 32'd1);
    check("b2b gap pselx",   32'(pselx), 32'd0);
    @(negedge pclk);
    trans = 1'b0;
    check("b2b second pselx",   32'(pselx), 32'b0010);
    check("b2b second penable", 32'(penable), 32'd0);
    check("b2b second paddr",   paddr, 32'h4000_0000);
    check("b2b second pwdata",  pwdata, 32'h2222_2222);
    check("b2b second done low", 32'(done), 32'd0);
    @(negedge pclk);
    @(negedge pclk);
    check("b2b second done", 32'(done), 32'd1);
    check("b2b second err",  32'(err), 32'd0);

    // Reset in the middle of ACCESS
    pready = 4'b0000;
    @(negedge pclk);
    trans = 1'b1; wr = 1'b1; addr = 32'h4000_0010; wdata = 32'hA5A5_0001;
    @(negedge pclk);
    trans = 1'b0;
    @(negedge pclk);
    check("midrst access pselx",   32'(pselx), 32'b0010);
    check("midrst access penable", 32'(penable), 32'd1);
    @(negedge pclk);
    #2 preset_n = 1'b0;
    #1;
    check("midrst pselx",   32'(pselx), 32'd0);
    check("midrst penable", 32'(penable), 32'd0);
    check("midrst done",    32'(done), 32'd0);
    check("midrst ready",   32'(ready), 32'd0);
    @(negedge pclk);
    preset_n = 1'b1;
    @(negedge pclk);
    check("midrst release ready", 32'(ready), 32'd1);
    check("midrst release done",  32'(done), 32'd0);
    check("midrst release pselx", 32'(pselx), 32'd0);

    // Decode error on the 3-slave instance
    @(negedge pclk);
    trans3 = 1'b1; wr3 = 1'b0; addr3 = 32'hC000_0000;
    @(negedge pclk);
    trans3 = 1'b0;
    check("decerr pselx",   32'(pselx3), 32'd0);
    check("decerr penable", 32'(penable3), 32'd0);
    check("decerr done",    32'(done3), 32'd1);
    check("decerr err",     32'(err3), 32'd1);
    check("decerr rdata",   rdata3, 32'd0);
    check("decerr ready",   32'(ready3), 32'd1);
    @(negedge pclk);
    check("decerr done cleared", 32'(done3), 32'd0);
    check("decerr err cleared",  32'(err3), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
